// File: rtl/irq_pkg.sv
// Shared types and register map for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2
  } irq_state_t;

  localparam int IRQ_LEVEL_W = 2;
  localparam int IRQ_VEC_W   = 4;
  localparam int MAX_SRC     = 16;

  localparam logic [2:0] PRIO0    = 3'd0;
  localparam logic [2:0] PRIO1    = 3'd1;
  localparam logic [2:0] PRIO2    = 3'd2;
  localparam logic [2:0] PRIO3    = 3'd3;
  localparam logic [2:0] ENABLE_L = 3'd4;
  localparam logic [2:0] ENABLE_H = 3'd5;
  localparam logic [2:0] FLAG_L   = 3'd6;
  localparam logic [2:0] FLAG_H   = 3'd7;

endpackage

// File: rtl/irq_priority_select.sv
// Combinational winner selection: highest priority among pending, enabled sources;
// ties resolve to the lowest index because only a strictly higher level replaces the winner.
module irq_priority_select
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 16
) (
  input  logic [NUM_SRC-1:0]     flags,
  input  logic [NUM_SRC-1:0]     enable,
  input  logic [2*NUM_SRC-1:0]   prio,
  output logic                   valid,
  output logic [IRQ_VEC_W-1:0]   index,
  output logic [IRQ_LEVEL_W-1:0] level
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    level = '0;
    // level starts at 0, so a prio of 0 (off) can never win
    for (int i = 0; i < NUM_SRC; i++) begin
      if (flags[i] && enable[i] && (prio[2*i +: IRQ_LEVEL_W] > level)) begin
        valid = 1'b1;
        index = IRQ_VEC_W'(i);
        level = prio[2*i +: IRQ_LEVEL_W];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detected flags, enable/priority registers on the bus,
// and a req/ack handshake offering one vector at a time to the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 16,
  parameter logic [23:0] BASE_ADDR = 24'h2020
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   bus_write,
  input  logic                   bus_read,
  input  logic [23:0]            bus_address_in,
  input  logic [7:0]             bus_data_in,
  output logic [7:0]             bus_data_out,
  input  logic [NUM_SRC-1:0]     irq_src,
  input  logic [1:0]             cpu_mask_level,
  input  logic                   cpu_irq_ack,
  output logic                   cpu_irq_req,
  output logic [IRQ_VEC_W-1:0]   cpu_irq_vector,
  output logic [IRQ_LEVEL_W-1:0] cpu_irq_level
);

  localparam logic [MAX_SRC-1:0]   SRC_MASK  = 16'((33'd1 << NUM_SRC) - 33'd1);
  localparam logic [2*MAX_SRC-1:0] PRIO_MASK = 32'((65'd1 << (2*NUM_SRC)) - 65'd1);

  logic [2*MAX_SRC-1:0] prio_q;
  logic [MAX_SRC-1:0]   enable_q;
  logic [MAX_SRC-1:0]   flag_q;
  logic [NUM_SRC-1:0]   src_prev_q;
  logic                 armed_q;

  logic [23:0]          offs;
  logic                 hit;
  logic [2:0]           reg_sel;
  logic                 wr_en;
  logic [MAX_SRC-1:0]   flag_clr;
  logic [MAX_SRC-1:0]   rise;
  logic                 bus_read_unused;

  irq_state_t             state_q;
  logic [IRQ_VEC_W-1:0]   vec_q;
  logic [IRQ_LEVEL_W-1:0] lvl_q;
  logic                   win_valid;
  logic [IRQ_VEC_W-1:0]   win_idx;
  logic [IRQ_LEVEL_W-1:0] win_lvl;
  logic                   still_pending;

  // Reads have no side effects, so the strobe carries no information here.
  assign bus_read_unused = bus_read;

  assign offs    = bus_address_in - BASE_ADDR;
  assign hit     = (offs[23:3] == '0);
  assign reg_sel = offs[2:0];
  assign wr_en   = bus_write & hit;

  // armed_q keeps a line that is already high at reset release from looking like an edge
  assign rise = 16'(irq_src & ~src_prev_q) & {MAX_SRC{armed_q}};

  always_comb begin
    flag_clr = '0;
    if (wr_en && reg_sel == FLAG_L) flag_clr[7:0]  = bus_data_in;
    if (wr_en && reg_sel == FLAG_H) flag_clr[15:8] = bus_data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q     <= '0;
      enable_q   <= '0;
      flag_q     <= '0;
      src_prev_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      src_prev_q <= irq_src;
      // a new edge beats a same-cycle write-1-clear
      flag_q     <= ((flag_q & ~flag_clr) | rise) & SRC_MASK;
      if (wr_en) begin
        case (reg_sel)
          PRIO0, PRIO1, PRIO2, PRIO3:
            prio_q[{reg_sel[1:0], 3'b000} +: 8] <=
              bus_data_in & PRIO_MASK[{reg_sel[1:0], 3'b000} +: 8];
          ENABLE_L: enable_q[7:0]  <= bus_data_in & SRC_MASK[7:0];
          ENABLE_H: enable_q[15:8] <= bus_data_in & SRC_MASK[15:8];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus_data_out = 8'h00;
    if (hit) begin
      case (reg_sel)
        PRIO0, PRIO1, PRIO2, PRIO3: bus_data_out = prio_q[{reg_sel[1:0], 3'b000} +: 8];
        ENABLE_L: bus_data_out = enable_q[7:0];
        ENABLE_H: bus_data_out = enable_q[15:8];
        FLAG_L:   bus_data_out = flag_q[7:0];
        FLAG_H:   bus_data_out = flag_q[15:8];
        default:  bus_data_out = 8'h00;
      endcase
    end
  end

  irq_priority_select #(.NUM_SRC(NUM_SRC)) u_select (
    .flags  (flag_q[NUM_SRC-1:0]),
    .enable (enable_q[NUM_SRC-1:0]),
    .prio   (prio_q[2*NUM_SRC-1:0]),
    .valid  (win_valid),
    .index  (win_idx),
    .level  (win_lvl)
  );

  assign still_pending = flag_q[vec_q] & enable_q[vec_q] & (prio_q[{vec_q, 1'b0} +: 2] != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      lvl_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid && (win_lvl > cpu_mask_level)) begin
            state_q <= REQ;
            vec_q   <= win_idx;
            lvl_q   <= win_lvl;
          end
        end
        // ack takes precedence over a withdraw in the same cycle
        REQ: begin
          if (cpu_irq_ack)         state_q <= ACKED;
          else if (!still_pending) state_q <= IDLE;
        end
        ACKED:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_irq_req    = (state_q == REQ);
  assign cpu_irq_vector = vec_q;
  assign cpu_irq_level  = lvl_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomized scoreboard bench for irq_controller against a behavioural model of the
// register map, edge-flag rules and the offer/ack handshake.
module tb_irq_controller;

  localparam logic [23:0] BASE = 24'h2020;

  typedef struct packed {
    logic       req;
    logic [3:0] vec;
    logic [1:0] lvl;
    logic [7:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] bus_address_in = BASE;
  logic [7:0]  bus_data_in = 8'h00;
  logic [7:0]  bus_data_out;
  logic [15:0] irq_src = '0;
  logic [1:0]  cpu_mask_level = 2'd0;
  logic        cpu_irq_ack = 1'b0;
  logic        cpu_irq_req;
  logic [3:0]  cpu_irq_vector;
  logic [1:0]  cpu_irq_level;

  irq_controller #(.NUM_SRC(16), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .irq_src        (irq_src),
    .cpu_mask_level (cpu_mask_level),
    .cpu_irq_ack    (cpu_irq_ack),
    .cpu_irq_req    (cpu_irq_req),
    .cpu_irq_vector (cpu_irq_vector),
    .cpu_irq_level  (cpu_irq_level)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // behavioural model state
  int m_prio[16];
  bit m_en[16];
  bit m_flag[16];
  bit m_prev[16];
  bit m_armed;
  bit m_offer;
  bit m_cool;
  int m_vec;
  int m_lvl;

  logic [15:0] t_src = '0;
  logic [1:0]  t_mask = 2'd0;

  task automatic model_reset();
    for (int n = 0; n < 16; n++) begin
      m_prio[n] = 0; m_en[n] = 0; m_flag[n] = 0; m_prev[n] = 0;
    end
    m_armed = 0; m_offer = 0; m_cool = 0; m_vec = 0; m_lvl = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [23:0] a);
    int off;
    logic [7:0] r;
    off = int'(a) - int'(BASE);
    r = 8'h00;
    if (off >= 0 && off < 4) begin
      for (int k = 0; k < 4; k++) r[2*k +: 2] = 2'(m_prio[off*4 + k]);
    end else if (off == 4 || off == 5) begin
      for (int k = 0; k < 8; k++) r[k] = m_en[(off-4)*8 + k];
    end else if (off == 6 || off == 7) begin
      for (int k = 0; k < 8; k++) r[k] = m_flag[(off-6)*8 + k];
    end
    return r;
  endfunction

  task automatic model_step(input logic wr, input logic [23:0] a, input logic [7:0] d,
                            input logic [15:0] src, input logic [1:0] mask, input logic ack);
    int off, wv, wl;
    bit found;
    bit clr[16];
    found = 0; wv = 0; wl = 0;
    for (int p = 3; p >= 1; p--)
      for (int n = 0; n < 16; n++)
        if (!found && m_flag[n] && m_en[n] && m_prio[n] == p) begin
          found = 1; wv = n; wl = p;
        end
    if (m_offer) begin
      if (ack) begin m_offer = 0; m_cool = 1; end
      else if (!(m_flag[m_vec] && m_en[m_vec] && m_prio[m_vec] != 0)) m_offer = 0;
    end else if (m_cool) begin
      m_cool = 0;
    end else if (found && wl > int'(mask)) begin
      m_offer = 1; m_vec = wv; m_lvl = wl;
    end
    for (int n = 0; n < 16; n++) clr[n] = 0;
    off = int'(a) - int'(BASE);
    if (wr && off >= 0 && off < 8) begin
      if (off < 4) for (int k = 0; k < 4; k++) m_prio[off*4 + k] = int'(d[2*k +: 2]);
      else if (off < 6) for (int k = 0; k < 8; k++) m_en[(off-4)*8 + k] = d[k];
      else for (int k = 0; k < 8; k++) clr[(off-6)*8 + k] = d[k];
    end
    for (int n = 0; n < 16; n++) begin
      m_flag[n] = (m_flag[n] && !clr[n]) || (m_armed && src[n] && !m_prev[n]);
      m_prev[n] = src[n];
    end
    m_armed = 1;
  endtask

  // One clock: advance the model over the edge just taken, then apply new inputs.
  task automatic cycle(input bit rst, input bit wr, input logic [23:0] a, input logic [7:0] d,
                       input logic [15:0] src, input logic [1:0] mask, input bit ack);
    exp_t e;
    @(posedge clk);
    #1;
    if (reset_n) model_step(bus_write, bus_address_in, bus_data_in, irq_src, cpu_mask_level, cpu_irq_ack);
    reset_n = !rst;
    if (rst) model_reset();
    bus_write = wr; bus_read = !wr; bus_address_in = a; bus_data_in = d;
    irq_src = src; cpu_mask_level = mask; cpu_irq_ack = ack;
    e.req = m_offer; e.vec = 4'(m_vec); e.lvl = 2'(m_lvl); e.rd = model_read(a);
    exp_q.push_back(e);
  endtask

  task automatic wr_reg(input int off, input logic [7:0] d);
    cycle(0, 1, BASE + 24'(off), d, t_src, t_mask, 0);
  endtask

  task automatic idle(input int n, input int off);
    for (int i = 0; i < n; i++) cycle(0, 0, BASE + 24'(off), 8'h00, t_src, t_mask, 0);
  endtask

  task automatic pulse(input logic [15:0] bits);
    t_src = t_src | bits;
    idle(1, 6);
    t_src = t_src & ~bits;
  endtask

  task automatic ack_cyc();
    cycle(0, 0, BASE + 24'd6, 8'h00, t_src, t_mask, 1);
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({cpu_irq_req, cpu_irq_vector, cpu_irq_level, bus_data_out} !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got req=%0b vec=%0d lvl=%0d rd=%h, expected req=%0b vec=%0d lvl=%0d rd=%h",
                   $time, cpu_irq_req, cpu_irq_vector, cpu_irq_level, bus_data_out,
                   e.req, e.vec, e.lvl, e.rd);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rs;
    logic [23:0] ra;
    bit          rw, rk, rr;
    model_reset();
    cycle(1, 0, BASE, 8'h00, '0, 2'd0, 0);
    cycle(1, 0, BASE + 24'd6, 8'h00, '0, 2'd0, 0);

    // single source, ack, then software clear
    wr_reg(0, 8'h80);
    wr_reg(4, 8'h08);
    pulse(16'h0008);
    idle(3, 6);
    ack_cyc();
    idle(3, 6);
    wr_reg(6, 8'h08);
    idle(2, 6);

    // reset while a request is outstanding, then read every register
    pulse(16'h0008);
    idle(2, 6);
    cycle(1, 0, BASE + 24'd6, 8'h00, t_src, t_mask, 0);
    cycle(1, 0, BASE, 8'h00, t_src, t_mask, 0);
    for (int off = 0; off < 9; off++) idle(1, off);

    // priority and mask gating
    wr_reg(0, 8'h04);
    wr_reg(1, 8'h0C);
    wr_reg(2, 8'h0C);
    wr_reg(4, 8'h22);
    wr_reg(5, 8'h02);
    t_mask = 2'd3;
    pulse(16'h0222);
    idle(3, 6);
    t_mask = 2'd2;
    idle(3, 7);
    ack_cyc();
    idle(2, 6);
    wr_reg(6, 8'h22);
    wr_reg(7, 8'h02);
    t_mask = 2'd0;
    idle(2, 6);

    // withdraw by clearing the offered flag
    wr_reg(0, 8'h10);
    wr_reg(4, 8'h04);
    pulse(16'h0004);
    idle(3, 6);
    wr_reg(6, 8'h04);
    idle(3, 6);

    // edge and write-1-clear in the same cycle
    t_src[0] = 1'b1;
    cycle(0, 1, BASE + 24'd6, 8'h01, t_src, t_mask, 0);
    t_src[0] = 1'b0;
    idle(2, 6);
    wr_reg(6, 8'h01);

    // latch while disabled, later enable, level-held line
    wr_reg(4, 8'h00);
    wr_reg(1, 8'h40);
    pulse(16'h0080);
    idle(3, 6);
    wr_reg(4, 8'h80);
    idle(4, 6);
    t_src[7] = 1'b1;
    idle(2, 6);
    wr_reg(6, 8'hFF);
    idle(4, 6);
    t_src[7] = 1'b0;
    idle(1, 6);

    // randomized traffic
    rs = '0;
    for (int c = 0; c < 2000; c++) begin
      rs = rs ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 19) == 0) t_mask = 2'($urandom);
      rw = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) ra = 24'($urandom);
      else ra = BASE + 24'($urandom_range(0, 9));
      rk = m_offer ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 399) == 0);
      cycle(rr, rw, ra, 8'($urandom), rs, t_mask, rk);
    end
    cycle(0, 0, BASE + 24'd6, 8'h00, rs, t_mask, 0);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
